// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core sequencer: FSM states, RV32I major opcodes, ebreak encoding.
package npc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int NUM_LEGAL_OPS = 10;
  localparam logic [6:0] LEGAL_OPS [NUM_LEGAL_OPS] = '{
    OP_IMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL,
    OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_SYSTEM
  };

  localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/npc_ctrl_dec.sv
// Combinational instruction classifier: opcode legality, rd-writing class and ebreak detection.
module npc_ctrl_dec
  import npc_pkg::*;
(
  input  logic [31:0] inst,
  output logic        legal,
  output logic        writes_rd,
  output logic        is_ebreak
);

  logic [NUM_LEGAL_OPS-1:0] op_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEGAL_OPS; gi++) begin : g_legal
      assign op_hit[gi] = (inst[6:0] == LEGAL_OPS[gi]);
    end
  endgenerate

  assign legal     = |op_hit;
  assign is_ebreak = (inst == EBREAK);

  always_comb begin
    writes_rd = 1'b0;
    case (inst[6:0])
      OP_IMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_core_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch, execute strobe, writeback, PC advance.
// One instruction in flight; halts on ebreak or on any fault (trap_err distinguishes them).
module npc_core_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] inst,
  output logic        exu_en,
  input  logic [31:0] exu_result,
  input  logic [31:0] exu_next_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halt,
  output logic        trap_err
);

  // Counter holds cycles already spent in the fetch state, so the last allowed cycle is TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] instret_reg, instret_next;
  logic [31:0] result_reg, result_next;
  logic [31:0] npc_reg, npc_next;
  logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
  logic        trap_reg, trap_next;

  logic dec_legal, dec_writes_rd, dec_is_ebreak;
  logic req_valid_next, exu_en_next, rf_we_next;

  npc_ctrl_dec u_dec (
    .inst      (inst_reg),
    .legal     (dec_legal),
    .writes_rd (dec_writes_rd),
    .is_ebreak (dec_is_ebreak)
  );

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    inst_next      = inst_reg;
    instret_next   = instret_reg;
    result_next    = result_reg;
    npc_next       = npc_reg;
    tmo_cnt_next   = '0;
    trap_next      = trap_reg;
    req_valid_next = 1'b0;
    exu_en_next    = 1'b0;
    rf_we_next     = 1'b0;

    case (state_reg)
      ST_FETCH_REQ: begin
        req_valid_next = 1'b1;
        if (imem_req_ready) begin
          state_next = ST_FETCH_WAIT;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = ST_HALT;
          trap_next  = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
      end
      ST_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_next = ST_HALT;
            trap_next  = 1'b1;
          end else begin
            inst_next  = imem_rsp_data;
            state_next = ST_EXEC;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = ST_HALT;
          trap_next  = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
      end
      ST_EXEC: begin
        exu_en_next = 1'b1;
        if (dec_is_ebreak) begin
          state_next = ST_HALT;
          trap_next  = 1'b0;
        end else if (!dec_legal) begin
          state_next = ST_HALT;
          trap_next  = 1'b1;
        end else begin
          result_next = exu_result;
          npc_next    = exu_next_pc;
          state_next  = ST_WB;
        end
      end
      ST_WB: begin
        if (npc_reg[1:0] != 2'b00) begin
          state_next = ST_HALT;
          trap_next  = 1'b1;
        end else begin
          rf_we_next   = dec_writes_rd && (inst_reg[11:7] != 5'd0);
          pc_next      = npc_reg;
          instret_next = instret_reg + 32'd1;
          state_next   = ST_FETCH_REQ;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH_REQ;
      pc_reg      <= RESET_PC;
      inst_reg    <= '0;
      instret_reg <= '0;
      result_reg  <= '0;
      npc_reg     <= '0;
      tmo_cnt_reg <= '0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      instret_reg <= instret_next;
      result_reg  <= result_next;
      npc_reg     <= npc_next;
      tmo_cnt_reg <= tmo_cnt_next;
      trap_reg    <= trap_next;
    end
  end

  assign imem_req_valid = req_valid_next;
  assign imem_req_addr  = pc_reg;
  assign exu_en         = exu_en_next;
  assign rf_we          = rf_we_next;
  assign rf_waddr       = inst_reg[11:7];
  assign rf_wdata       = result_reg;
  assign inst           = inst_reg;
  assign pc             = pc_reg;
  assign instret        = instret_reg;
  assign halt           = (state_reg == ST_HALT);
  assign trap_err       = trap_reg;

endmodule

// File: tb/tb_npc_core_ctrl.sv
// Self-checking bench: plays instruction memory and EXU, tracks PC/instret/halt with an abstract model.
module tb_npc_core_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic [31:0] inst;
  logic        exu_en;
  logic [31:0] exu_result = '0;
  logic [31:0] exu_next_pc = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halt;
  logic        trap_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instret;
  logic        m_halt, m_trap;
  logic [6:0]  legal_ops [10] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011};

  npc_core_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst(inst), .exu_en(exu_en), .exu_result(exu_result), .exu_next_pc(exu_next_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .instret(instret), .halt(halt), .trap_err(trap_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit op_legal(input logic [31:0] w);
    case (w[6:0])
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit op_writes(input logic [31:0] w);
    case (w[6:0])
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111, 7'b0000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_pc = RESET_PC;
    m_instret = '0;
    m_halt = 1'b0;
    m_trap = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    chk({tag, "_halt"}, halt, m_halt);
    chk({tag, "_trap"}, trap_err, m_trap);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_instret"}, instret, m_instret);
  endtask

  // One complete instruction: request handshake, response, EXEC, WB, per the model's rules.
  task automatic run_inst(input logic [31:0] w, input int rdy_dly, input int rsp_dly,
                          input logic err, input logic [31:0] res, input logic [31:0] npc);
    bit we;
    for (int i = 0; i < rdy_dly; i++) begin
      chk("req_valid_held", imem_req_valid, 1);
      chk("req_addr_held", imem_req_addr, m_pc);
      tick();
    end
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, m_pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      chk("wait_strobes", {imem_req_valid, exu_en, rf_we}, 0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = w;
    imem_rsp_err = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    if (err) begin
      m_halt = 1'b1;
      m_trap = 1'b1;
    end else begin
      chk("exu_en", exu_en, 1);
      chk("inst", inst, w);
      exu_result = res;
      exu_next_pc = npc;
      if (w == EBREAK_W) begin
        m_halt = 1'b1;
        m_trap = 1'b0;
        tick();
      end else if (!op_legal(w)) begin
        m_halt = 1'b1;
        m_trap = 1'b1;
        tick();
      end else begin
        tick();
        we = op_writes(w) && (w[11:7] != 5'd0) && (npc[1:0] == 2'b00);
        chk("rf_we", rf_we, we);
        if (we) begin
          chk("rf_waddr", rf_waddr, w[11:7]);
          chk("rf_wdata", rf_wdata, res);
        end
        if (npc[1:0] != 2'b00) begin
          m_halt = 1'b1;
          m_trap = 1'b1;
        end else begin
          m_pc = npc;
          m_instret = m_instret + 1;
        end
        tick();
      end
    end
    check_arch("post");
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      tick();
      chk("halt_strobes", {imem_req_valid, exu_en, rf_we}, 0);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    check_arch("halted");
  endtask

  initial begin
    logic [31:0] w, npc;

    // Reset state and a single addi at minimum latency
    do_reset();
    chk("rst_inst", inst, 0);
    chk("rst_strobes", {exu_en, rf_we}, 0);
    chk("rst_req_valid", imem_req_valid, 1);
    check_arch("rst");
    run_inst(32'h0050_0093, 0, 0, 1'b0, 32'd5, 32'h8000_0004);

    // Request held while ready is low
    do_reset();
    run_inst(32'h0070_0113, 3, 2, 1'b0, 32'd7, 32'h8000_0010);

    // PC wrap, then x0 destination (no write)
    run_inst(32'h0000_006f, 0, 1, 1'b0, 32'h8000_0014, 32'hFFFF_FFFC);
    run_inst(32'h0010_0013, 1, 0, 1'b0, 32'h1234_5678, 32'h0000_0000);

    // Randomized legal, non-halting instructions with random handshake delays
    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      w[6:0] = legal_ops[$urandom_range(0, 9)];
      if (w == EBREAK_W) w[31] = 1'b1;
      npc = $urandom;
      npc[1:0] = 2'b00;
      run_inst(w, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, $urandom, npc);
    end

    // ebreak: clean stop, nothing retired, no more requests
    run_inst(EBREAK_W, 0, 0, 1'b0, 32'd0, 32'h0);
    halt_idle(5);

    // Faults: bus error, illegal opcode, misaligned next PC
    do_reset();
    run_inst(32'h0050_0093, 0, 0, 1'b1, 32'd0, 32'h0);
    halt_idle(2);
    do_reset();
    run_inst(32'h0000_0000, 0, 1, 1'b0, 32'd0, 32'h0);
    halt_idle(2);
    do_reset();
    run_inst(32'h0050_0093, 0, 0, 1'b0, 32'd5, 32'h8000_0006);
    halt_idle(2);

    // Fetch timeout: no response for 255 cycles in FETCH_WAIT
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    chk("tmo_not_yet", halt, 0);
    tick();
    m_halt = 1'b1;
    m_trap = 1'b1;
    check_arch("tmo");

    // Reset during FETCH_WAIT; stale response afterwards must be ignored
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0050_0093;
    chk("stale_req_valid", imem_req_valid, 1);
    chk("stale_req_addr", imem_req_addr, RESET_PC);
    tick();
    imem_rsp_valid = 1'b0;
    chk("stale_inst", inst, 0);
    chk("stale_exu_en", exu_en, 0);
    run_inst(32'h0030_0193, 0, 0, 1'b0, 32'd3, 32'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
